// File: rtl/step_ex_pkg.sv
// step_ex_pkg: register ids and step state encoding shared by the step_ex_* blocks
package step_ex_pkg;
  localparam logic [3:0] REG_R0 = 4'd0;
  localparam logic [3:0] REG_R1 = 4'd1;
  localparam logic [3:0] REG_R2 = 4'd2;
  localparam logic [3:0] REG_R3 = 4'd3;
  localparam logic [3:0] REG_R4 = 4'd4;
  localparam logic [3:0] REG_R5 = 4'd5;
  localparam logic [3:0] REG_FL = 4'd10;
  localparam logic [3:0] REG_PC = 4'd15;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2
  } step_state_e;
endpackage

// File: rtl/step_ex_cpf_if.sv
// step_ex_cpf_if: shared execute-step bus; released lines float high so an idle bus reads all-ones
interface step_ex_cpf_if;
  logic       ena_;
  logic [3:0] reg_id;
  tri1        rdy_;
  tri1        r0_we_;
  tri1  [7:0] r0_din;
  modport master (output ena_, reg_id, input rdy_, r0_we_, r0_din);
  modport slave (input ena_, reg_id, output rdy_, r0_we_, r0_din);
endinterface

// File: rtl/step_ex_cpf_reg_src_mux.sv
// reg_src_mux: selects the register named by reg_id, with a fixed value for unimplemented ids
module reg_src_mux
  import step_ex_pkg::*;
#(
  parameter logic [7:0] UNMAPPED_VAL = 8'h00
) (
  input  logic [3:0] reg_id,
  input  logic [7:0] r0_dout,
  input  logic [7:0] r1_dout,
  input  logic [7:0] r2_dout,
  input  logic [7:0] r3_dout,
  input  logic [7:0] r4_dout,
  input  logic [7:0] r5_dout,
  input  logic [7:0] fl_dout,
  input  logic [7:0] pc_dout,
  output logic [7:0] src
);
  always_comb begin
    src = UNMAPPED_VAL;
    case (reg_id)
      REG_R0:  src = r0_dout;
      REG_R1:  src = r1_dout;
      REG_R2:  src = r2_dout;
      REG_R3:  src = r3_dout;
      REG_R4:  src = r4_dout;
      REG_R5:  src = r5_dout;
      REG_FL:  src = fl_dout;
      REG_PC:  src = pc_dout;
      default: src = UNMAPPED_VAL;
    endcase
  end
endmodule

// File: rtl/step_ex_cpf.sv
// step_ex_cpf: copies the register named by reg_id into r0, driving the shared bus only while active
module step_ex_cpf
  import step_ex_pkg::*;
#(
  parameter logic [7:0] UNMAPPED_VAL = 8'h00
) (
  input  logic         clk,
  input  logic         rst_,
  step_ex_cpf_if.slave bus,
  input  logic [7:0]   r0_dout,
  input  logic [7:0]   r1_dout,
  input  logic [7:0]   r2_dout,
  input  logic [7:0]   r3_dout,
  input  logic [7:0]   r4_dout,
  input  logic [7:0]   r5_dout,
  input  logic [7:0]   fl_dout,
  input  logic [7:0]   pc_dout
);
  step_state_e state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  src;
  reg_src_mux #(.UNMAPPED_VAL(UNMAPPED_VAL)) u_mux (
    .reg_id (bus.reg_id),
    .r0_dout(r0_dout),
    .r1_dout(r1_dout),
    .r2_dout(r2_dout),
    .r3_dout(r3_dout),
    .r4_dout(r4_dout),
    .r5_dout(r5_dout),
    .fl_dout(fl_dout),
    .pc_dout(pc_dout),
    .src    (src)
  );
  // a new start always wins, aborting any move in flight before it writes
  always_comb begin
    state_d = ST_IDLE;
    hold_d  = hold_q;
    if (!bus.ena_) begin
      state_d = ST_FETCH;
      hold_d  = src;
    end else if (state_q == ST_FETCH) begin
      state_d = ST_WRITE;
    end
  end
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      hold_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end
  assign bus.r0_din = (state_q == ST_FETCH || state_q == ST_WRITE) ? hold_q : 8'bz;
  assign bus.r0_we_ = (state_q == ST_WRITE) ? 1'b0 : 1'bz;
  assign bus.rdy_   = (state_q == ST_WRITE) ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_step_ex_cpf.sv
// tb_step_ex_cpf: directed and random moves checked against a timeline model; released lines read as pulled-up ones
module tb_step_ex_cpf;
  import step_ex_pkg::*;
  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic [7:0] dout [8];
  int         tests = 0;
  int         fails = 0;
  int         age = 9;
  logic [7:0] hold_a = 8'h00;
  logic [7:0] hold_b = 8'h00;
  step_ex_cpf_if bus_a ();
  step_ex_cpf_if bus_b ();
  step_ex_cpf dut_a (
    .clk(clk), .rst_(rst_), .bus(bus_a.slave),
    .r0_dout(dout[0]), .r1_dout(dout[1]), .r2_dout(dout[2]), .r3_dout(dout[3]),
    .r4_dout(dout[4]), .r5_dout(dout[5]), .fl_dout(dout[6]), .pc_dout(dout[7])
  );
  step_ex_cpf #(.UNMAPPED_VAL(8'hFF)) dut_b (
    .clk(clk), .rst_(rst_), .bus(bus_b.slave),
    .r0_dout(dout[0]), .r1_dout(dout[1]), .r2_dout(dout[2]), .r3_dout(dout[3]),
    .r4_dout(dout[4]), .r5_dout(dout[5]), .fl_dout(dout[6]), .pc_dout(dout[7])
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] ref_src(input logic [3:0] id, input logic [7:0] unm);
    if (id <= 4'd5) return dout[int'(id)];
    if (id == REG_FL) return dout[6];
    if (id == REG_PC) return dout[7];
    return unm;
  endfunction
  // age counts edges since the last start; 0 = setup cycle, 1 = write cycle, later = released
  always @(posedge clk or negedge rst_) begin
    if (!rst_) age <= 9;
    else if (!bus_a.ena_) begin
      age    <= 0;
      hold_a <= ref_src(bus_a.reg_id, 8'h00);
      hold_b <= ref_src(bus_b.reg_id, 8'hFF);
    end else if (age < 9) age <= age + 1;
  end
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_bus();
    chk("a_din", bus_a.r0_din, age <= 1 ? hold_a : 8'hFF);
    chk("a_we", {7'd0, bus_a.r0_we_}, age == 1 ? 8'd0 : 8'd1);
    chk("a_rdy", {7'd0, bus_a.rdy_}, age == 1 ? 8'd0 : 8'd1);
    chk("b_din", bus_b.r0_din, age <= 1 ? hold_b : 8'hFF);
    chk("b_we", {7'd0, bus_b.r0_we_}, age == 1 ? 8'd0 : 8'd1);
    chk("b_rdy", {7'd0, bus_b.rdy_}, age == 1 ? 8'd0 : 8'd1);
  endtask
  task automatic set_in(input logic e, input logic [3:0] id);
    bus_a.ena_ = e; bus_b.ena_ = e;
    bus_a.reg_id = id; bus_b.reg_id = id;
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    check_bus();
  endtask
  initial begin
    for (int i = 0; i < 8; i++) dout[i] = 8'($urandom);
    set_in(1'b1, 4'd0);
    #1 check_bus();
    repeat (2) cyc();
    rst_ = 1'b1;
    cyc();
    dout[3] = 8'h5A; set_in(1'b0, 4'd3); cyc();
    chk("r3_din", bus_a.r0_din, 8'h5A);
    set_in(1'b1, 4'd3); cyc();
    chk("r3_we", {7'd0, bus_a.r0_we_}, 8'd0);
    chk("r3_rdy", {7'd0, bus_a.rdy_}, 8'd0);
    cyc();
    chk("r3_rdy_rel", {7'd0, bus_a.rdy_}, 8'd1);
    dout[7] = 8'hC3; set_in(1'b0, 4'd15); cyc();
    dout[7] = 8'h00; set_in(1'b1, 4'd15); cyc();
    chk("pc_din_held", bus_a.r0_din, 8'hC3);
    cyc();
    set_in(1'b0, 4'd7); cyc();
    set_in(1'b1, 4'd7); cyc();
    chk("unm_a", bus_a.r0_din, 8'h00);
    chk("unm_b", bus_b.r0_din, 8'hFF);
    chk("unm_we", {7'd0, bus_a.r0_we_}, 8'd0);
    cyc();
    dout[6] = 8'h81; set_in(1'b0, 4'd10); cyc();
    set_in(1'b1, 4'd10); cyc();
    chk("fl_din", bus_a.r0_din, 8'h81);
    dout[2] = 8'h17; set_in(1'b0, 4'd2); cyc();
    chk("abort_we", {7'd0, bus_a.r0_we_}, 8'd1);
    chk("abort_din", bus_a.r0_din, 8'h17);
    set_in(1'b1, 4'd2); cyc();
    chk("abort_wr", bus_a.r0_din, 8'h17);
    chk("abort_rdy", {7'd0, bus_a.rdy_}, 8'd0);
    cyc();
    set_in(1'b0, 4'd1); cyc();
    set_in(1'b1, 4'd1);
    #2 rst_ = 1'b0;
    #1 check_bus();
    chk("rst_din", bus_a.r0_din, 8'hFF);
    chk("rst_rdy", {7'd0, bus_a.rdy_}, 8'd1);
    cyc();
    rst_ = 1'b1;
    repeat (3) cyc();
    repeat (10) cyc();
    chk("idle_rdy", {7'd0, bus_a.rdy_}, 8'd1);
    set_in(1'b0, 4'd4);
    repeat (5) begin dout[4] = 8'($urandom); cyc(); end
    set_in(1'b1, 4'd4); cyc(); cyc();
    repeat (300) begin
      for (int i = 0; i < 8; i++) dout[i] = 8'($urandom);
      set_in($urandom_range(0, 2) == 0 ? 1'b0 : 1'b1, 4'($urandom));
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
